image_proc_arb: RTL and testbench
=================================

IMAGE_PROC_ARB -- requirements
Module: image_proc_arb

Interface
REQ-001 Parameter DATA_BW, default 8, pixel width in bits.
REQ-002 Parameter TAG_DEPTH, default 4, max in-flight transactions (power of 2, >=2).
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_req0_valid / i_req1_valid  input  1  requester N has a 3x3 window.
REQ-006 i_req0_data / i_req1_data  input  DATA_BW*9  window, pixel 0 in MSBs.
REQ-007 i_req0_cfg / i_req1_cfg  input  2  filter select for that window.
REQ-008 o_req0_ready / o_req1_ready  output  1  window accepted this cycle.
REQ-009 o_ip_valid  output  1  window valid toward image_proc.
REQ-010 o_ip_data  output  DATA_BW*9  granted window.
REQ-011 o_ip_cfg  output  2  granted config select, drives image_proc i_config_select.
REQ-012 i_ip_ready  input  1  image_proc input ready.
REQ-013 i_ip_out_valid  input  1  image_proc result valid.
REQ-014 i_ip_out_data  input  DATA_BW  image_proc result pixel.
REQ-015 o_ip_out_ready  output  1  result consumed.
REQ-016 o_rsp0_valid / o_rsp1_valid  output  1  result for requester N.
REQ-017 o_rsp0_data / o_rsp1_data  output  DATA_BW  result pixel, both driven from i_ip_out_data.
REQ-018 i_rsp0_ready / i_rsp1_ready  input  1  requester N accepts result.
REQ-019 o_inflight  output  $clog2(TAG_DEPTH+1)  tag FIFO occupancy.
REQ-020 o_err  output  1  sticky: result arrived with no outstanding tag.

Function
REQ-021 Arbitration SHALL be round-robin over two requesters using a last-grant register: if only one valid, grant it; if both valid, grant the one not last granted.
REQ-022 Grant SHALL lock while o_ip_valid=1 and i_ip_ready=0; grant, o_ip_data and o_ip_cfg SHALL not change until handshake.
REQ-023 o_ip_valid SHALL be (granted requester valid) AND tag FIFO not full; o_ip_data/o_ip_cfg SHALL mux the granted requester, zero when o_ip_valid=0.
REQ-024 o_reqN_ready SHALL be 1 only when grant=N, o_ip_valid=1 and i_ip_ready=1; non-granted ready SHALL be 0.
REQ-025 On input handshake the granted ID SHALL be pushed into the tag FIFO and last-grant updated the same edge.
REQ-026 When FIFO full, no push SHALL occur even if a pop occurs that cycle (o_ip_valid=0 when full).
REQ-027 Head tag H: o_rspH_valid = i_ip_out_valid AND FIFO non-empty; other o_rsp valid 0.
REQ-028 o_ip_out_ready = FIFO non-empty AND i_rspH_ready; pop on i_ip_out_valid AND o_ip_out_ready.
REQ-029 Simultaneous push and pop (FIFO not full) SHALL leave o_inflight unchanged; pointers wrap modulo TAG_DEPTH.
REQ-030 i_ip_out_valid with FIFO empty SHALL drive o_ip_out_ready=1 (drain), no o_rsp valid, set o_err until reset.
REQ-031 Latency: zero added cycles on both paths (combinational forwarding); tag bookkeeping registered.
REQ-032 Requesters SHALL hold valid/data/cfg until ready; arbiter makes no progress guarantee otherwise.

Reset
REQ-033 While i_rstn=0: FIFO empty, o_inflight=0, o_err=0, last-grant=1 (requester 0 wins first tie), lock cleared.
REQ-034 Under reset all outputs SHALL be 0; in-flight tags discarded; mid-transaction reset drops pending results without o_err.

Verification
REQ-035 Both valid, i_ip_ready=1 continuously, 4 cycles -> grants 0,1,0,1; o_ip_cfg follows each requester's cfg.
REQ-036 Req0 valid, i_ip_ready=0 for 3 cycles, req1 raises valid cycle 1 -> grant stays 0, o_ip_data stable, req0 accepted cycle 3.
REQ-037 Push 4 windows with no results -> o_inflight=4, o_ip_valid=0 with requester valid; one result pop -> next push next cycle.
REQ-038 Push IDs 1,0,1; results 0x11,0x22,0x33 -> rsp1 gets 0x11, rsp0 0x22, rsp1 0x33; i_rsp1_ready=0 stalls o_ip_out_ready.
REQ-039 i_ip_out_valid with o_inflight=0 -> o_ip_out_ready=1, no rsp valid, o_err=1 until i_rstn low.
REQ-040 Assert i_rstn low with o_inflight=2 -> all outputs 0 asynchronously; after release first tie grants requester 0.

Source files
------------

// File: rtl/image_proc_arb.sv
// Two-requester round-robin front end for image_proc: forwards the granted 3x3
// window and routes each result back to its originator through an in-order tag FIFO.
module image_proc_arb #(
  parameter int DATA_BW   = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rstn,
  input  logic                             i_req0_valid,
  input  logic [DATA_BW*9-1:0]             i_req0_data,
  input  logic [1:0]                       i_req0_cfg,
  output logic                             o_req0_ready,
  input  logic                             i_req1_valid,
  input  logic [DATA_BW*9-1:0]             i_req1_data,
  input  logic [1:0]                       i_req1_cfg,
  output logic                             o_req1_ready,
  output logic                             o_ip_valid,
  output logic [DATA_BW*9-1:0]             o_ip_data,
  output logic [1:0]                       o_ip_cfg,
  input  logic                             i_ip_ready,
  input  logic                             i_ip_out_valid,
  input  logic [DATA_BW-1:0]               i_ip_out_data,
  output logic                             o_ip_out_ready,
  output logic                             o_rsp0_valid,
  output logic [DATA_BW-1:0]               o_rsp0_data,
  input  logic                             i_rsp0_ready,
  output logic                             o_rsp1_valid,
  output logic [DATA_BW-1:0]               o_rsp1_data,
  input  logic                             i_rsp1_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   o_inflight,
  output logic                             o_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic                 last_q, last_d;
  logic                 lock_q, lock_d;
  logic                 lgnt_q, lgnt_d;
  logic [TAG_DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic grant, gnt_valid, ip_valid, full, empty, push, pop, head, head_rdy;

  always_comb begin
    if (lock_q)                            grant = lgnt_q;
    else if (i_req0_valid && !i_req1_valid) grant = 1'b0;
    else if (i_req1_valid && !i_req0_valid) grant = 1'b1;
    else                                    grant = ~last_q;
    gnt_valid = grant ? i_req1_valid : i_req0_valid;
    full      = (cnt_q == FULL_CNT);
    empty     = (cnt_q == '0);
    // Full FIFO blocks the offer outright, so a same-cycle pop never enables a push.
    ip_valid  = i_rstn && gnt_valid && !full;
    push      = ip_valid && i_ip_ready;
    head      = tags_q[rd_q];
    head_rdy  = head ? i_rsp1_ready : i_rsp0_ready;
    pop       = i_rstn && i_ip_out_valid && !empty && head_rdy;
  end

  always_comb begin
    last_d = push ? grant : last_q;
    lock_d = ip_valid && !i_ip_ready;
    lgnt_d = grant;
    tags_d = tags_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    err_d  = err_q || (i_ip_out_valid && empty);
    if (push) begin
      tags_d[wr_q] = grant;
      wr_d         = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_q <= 1'b1;
      lock_q <= 1'b0;
      lgnt_q <= 1'b0;
      tags_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      lgnt_q <= lgnt_d;
      tags_q <= tags_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Combinational outputs are gated by i_rstn so they read zero during reset.
  always_comb begin
    o_ip_valid     = ip_valid;
    o_ip_data      = '0;
    o_ip_cfg       = '0;
    if (ip_valid) begin
      o_ip_data = grant ? i_req1_data : i_req0_data;
      o_ip_cfg  = grant ? i_req1_cfg  : i_req0_cfg;
    end
    o_req0_ready   = push && !grant;
    o_req1_ready   = push && grant;
    o_rsp0_valid   = i_rstn && i_ip_out_valid && !empty && !head;
    o_rsp1_valid   = i_rstn && i_ip_out_valid && !empty && head;
    o_rsp0_data    = i_rstn ? i_ip_out_data : '0;
    o_rsp1_data    = i_rstn ? i_ip_out_data : '0;
    o_ip_out_ready = i_rstn && (empty ? i_ip_out_valid : head_rdy);
    o_inflight     = cnt_q;
    o_err          = err_q;
  end

endmodule

// File: tb/tb_image_proc_arb.sv
// Directed bench for image_proc_arb: arbitration, lock, tag FIFO routing, full/empty and reset.
module tb_image_proc_arb;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [71:0] req0_data, req1_data, ip_data;
  logic [1:0]  req0_cfg, req1_cfg, ip_cfg;
  logic        ip_valid, ip_ready, out_valid, out_ready;
  logic [7:0]  out_data, rsp0_data, rsp1_data;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [2:0]  inflight;
  logic        err;
  int          checks = 0;
  int          errors = 0;

  localparam logic [71:0] W0 = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] W1 = 72'hA1_B2_C3_D4_E5_F6_17_28_39;

  always #5 clk = ~clk;

  image_proc_arb #(.DATA_BW(8), .TAG_DEPTH(4)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0_valid(req0_valid), .i_req0_data(req0_data), .i_req0_cfg(req0_cfg), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_data(req1_data), .i_req1_cfg(req1_cfg), .o_req1_ready(req1_ready),
    .o_ip_valid(ip_valid), .o_ip_data(ip_data), .o_ip_cfg(ip_cfg), .i_ip_ready(ip_ready),
    .i_ip_out_valid(out_valid), .i_ip_out_data(out_data), .o_ip_out_ready(out_ready),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_data(rsp0_data), .i_rsp0_ready(rsp0_ready),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_data(rsp1_data), .i_rsp1_ready(rsp1_ready),
    .o_inflight(inflight), .o_err(err)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; req0_valid = 1; req1_valid = 1; req0_data = W0; req1_data = W1;
    req0_cfg = 2'd1; req1_cfg = 2'd2; ip_ready = 1; out_valid = 1; out_data = 8'h5A;
    rsp0_ready = 1; rsp1_ready = 1;
    #2;
    chk("rst_ip_valid", ip_valid, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_out_ready", out_ready, 0);
    chk("rst_ip_data", ip_data, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    tick();
    out_valid = 0;
    rstn = 1;

    // Both valid, ip always ready: grants alternate 0,1,0,1 and fill the FIFO.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      chk("rr_cfg", ip_cfg, (k % 2 == 0) ? 2'd1 : 2'd2);
      chk("rr_data", ip_data, (k % 2 == 0) ? W0 : W1);
      tick();
    end
    chk("full_inflight", inflight, 4);
    chk("full_ip_valid", ip_valid, 0);
    chk("full_ready0", req0_ready, 0);
    out_valid = 1; out_data = 8'h11;
    #1;
    chk("fullpop_rsp0_valid", rsp0_valid, 1);
    chk("fullpop_rsp1_valid", rsp1_valid, 0);
    chk("fullpop_rsp0_data", rsp0_data, 8'h11);
    chk("fullpop_out_ready", out_ready, 1);
    chk("fullpop_no_push", ip_valid, 0);
    tick();
    chk("after_pop_inflight", inflight, 3);
    out_data = 8'h22;
    #1;
    chk("pushpop_ip_valid", ip_valid, 1);
    chk("pushpop_ready0", req0_ready, 1);
    chk("pushpop_rsp1_valid", rsp1_valid, 1);
    chk("pushpop_rsp0_valid", rsp0_valid, 0);
    tick();
    chk("pushpop_inflight", inflight, 3);
    req0_valid = 0; req1_valid = 0; out_data = 8'h33;
    #1;
    chk("pop3_rsp0_valid", rsp0_valid, 1);
    tick();
    out_valid = 0;
    chk("mid_inflight", inflight, 2);
    chk("mid_err", err, 0);

    // Mid-transaction asynchronous reset.
    req0_valid = 1; req1_valid = 1; out_valid = 1;
    #1 rstn = 0;
    #1;
    chk("arst_inflight", inflight, 0);
    chk("arst_ip_valid", ip_valid, 0);
    chk("arst_ready0", req0_ready, 0);
    chk("arst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("arst_out_ready", out_ready, 0);
    chk("arst_err", err, 0);
    tick();
    out_valid = 0;
    rstn = 1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    tick();

    // Lock: req0 stalled for 3 cycles, req1 arrives; last grant is 0 so only the lock keeps 0.
    req1_valid = 0; req0_cfg = 2'd3; ip_ready = 0;
    #1;
    chk("lock_ip_valid", ip_valid, 1);
    chk("lock_c0_data", ip_data, W0);
    chk("lock_c0_ready0", req0_ready, 0);
    tick();
    req1_valid = 1;
    #1;
    chk("lock_c1_data", ip_data, W0);
    chk("lock_c1_cfg", ip_cfg, 2'd3);
    chk("lock_c1_ready1", req1_ready, 0);
    tick();
    chk("lock_c2_data", ip_data, W0);
    tick();
    ip_ready = 1;
    #1;
    chk("lock_c3_ready0", req0_ready, 1);
    chk("lock_c3_ready1", req1_ready, 0);
    tick();
    chk("lock_inflight", inflight, 2);
    req0_valid = 0; req1_valid = 0;

    // Tag routing: push IDs 1,0,1 then return 0x11,0x22,0x33.
    rstn = 0;
    tick();
    rstn = 1; req1_valid = 1;
    #1 chk("tag_push1a", req1_ready, 1);
    tick();
    req1_valid = 0; req0_valid = 1;
    #1 chk("tag_push0", req0_ready, 1);
    tick();
    req0_valid = 0; req1_valid = 1;
    #1 chk("tag_push1b", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("tag_inflight", inflight, 3);
    out_valid = 1; out_data = 8'h11; rsp1_ready = 0;
    #1;
    chk("stall_rsp1_valid", rsp1_valid, 1);
    chk("stall_rsp0_valid", rsp0_valid, 0);
    chk("stall_out_ready", out_ready, 0);
    chk("stall_rsp1_data", rsp1_data, 8'h11);
    tick();
    chk("stall_inflight", inflight, 3);
    rsp1_ready = 1;
    #1 chk("unstall_out_ready", out_ready, 1);
    tick();
    out_data = 8'h22;
    #1;
    chk("r22_rsp0_valid", rsp0_valid, 1);
    chk("r22_rsp1_valid", rsp1_valid, 0);
    chk("r22_rsp0_data", rsp0_data, 8'h22);
    tick();
    out_data = 8'h33;
    #1;
    chk("r33_rsp1_valid", rsp1_valid, 1);
    chk("r33_rsp1_data", rsp1_data, 8'h33);
    tick();
    out_valid = 0;
    chk("drain_inflight", inflight, 0);

    // Unexpected result with nothing outstanding.
    out_valid = 1; out_data = 8'h77;
    #1;
    chk("orphan_out_ready", out_ready, 1);
    chk("orphan_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    tick();
    out_valid = 0;
    #1;
    chk("orphan_err", err, 1);
    chk("orphan_idle_ready", out_ready, 0);
    tick();
    chk("err_sticky", err, 1);
    rstn = 0;
    #1 chk("err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
